alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered ALU; successor to the 16-bit single-cycle ALU.
- Adds a start/busy/done handshake, overflow flag, borrow-aware subtract (SBB), shifts, and a multi-cycle unsigned shift-add multiplier with double-width result.
- Sits between the register file read ports and the writeback mux.
- The control unit issues one operation at a time and waits for done before issuing the next.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, width of the multiply iteration counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  4  operation select (encoding below).
- in_a  input  WIDTH  operand A, sampled with start.
- in_b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse: out/out_hi/flags updated this cycle.
- out  output  WIDTH  result (low half for MUL).
- out_hi  output  WIDTH  high half of MUL product; 0 after any other op.
- sign_flag  output  1  MSB of the result (out_hi MSB for MUL).
- c_flag  output  1  carry / borrow / shifted-out bit.
- zero_flag  output  1  result == 0 (full 2*WIDTH product for MUL).
- ovf_flag  output  1  signed overflow.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset: out, out_hi, all flags, busy, done, counter and state = 0; state = IDLE. Reset asserted mid-multiply aborts it; no done is produced.
- Op encoding:
  - 0 ADD, 1 ADC (a+b+c_flag), 2 SUB (a-b), 3 SBB (a-b-c_flag), 4 INC (a+1), 5 DEC (a-1).
  - 6 AND, 7 OR, 8 XOR, 9 NOT (~a), A SHL (a<<1), B SHR (logical a>>1), C MUL (unsigned a*b).
  - D-F reserved.
- States: IDLE, MUL.
- IDLE, start=1, op != C: compute with WIDTH+1-bit arithmetic and register result and flags at that edge; done=1 for the next cycle; stays IDLE. Latency 1 cycle; back-to-back starts every cycle are legal.
- IDLE, start=1, op=C:
  - Latch multiplicand and multiplier; clear accumulator; counter=0; busy=1; go to MUL.
  - MUL: one shift-add iteration per cycle for WIDTH cycles.
  - On the edge completing iteration WIDTH: out/out_hi/flags load, busy=0, done=1 for the following cycle, return to IDLE.
  - Total latency WIDTH cycles from start edge to result edge.
- start while busy=1: ignored; no queuing; operands are not re-sampled.
- done is 0 on every cycle except the single cycle after a result load.
- Outputs and flags hold their values until the next completed operation.
- Flags are computed from the new result, never from stale state.
- Add ops (ADD/ADC/INC): c_flag = carry out of bit WIDTH-1; ovf_flag = operands same sign and result sign differs.
- Sub ops (SUB/SBB/DEC): c_flag = borrow (1 when the unsigned minuend < subtrahend + borrow-in); ovf_flag = operands differ in sign and result sign differs from a.
- Logic ops (AND/OR/XOR/NOT): c_flag and ovf_flag cleared.
- SHL: c_flag = a[WIDTH-1]; ovf_flag = a[WIDTH-1]^a[WIDTH-2].
- SHR: c_flag = a[0]; ovf_flag = 0.
- MUL: c_flag = ovf_flag = (out_hi != 0).
- ADC/SBB use the c_flag value registered before the start edge.
- Reserved op: done pulses after 1 cycle; out, out_hi and flags unchanged.
- out_hi is forced to 0 on every non-MUL completion.

Test Plan:
- Reset while idle and during MUL cycle 5 -> all outputs 0, busy=0, no done pulse; next op executes normally.
- ADD 0xFFFF+0x0001 -> out=0x0000, C=1, Z=1, S=0, V=0; then ADC 0x0001+0x0001 -> out=0x0003, C=0.
- ADD 0x7FFF+0x0001 -> out=0x8000, V=1, S=1, C=0; SUB 0x0003-0x0005 -> out=0xFFFE, C=1 (borrow), V=0, S=1.
- SBB with C=1: 0x0010-0x0001 -> out=0x000E, C=0; DEC 0x0000 -> out=0xFFFF, C=1.
- MUL 0xFFFF*0xFFFF (WIDTH=16) -> busy high exactly 16 cycles; then out=0x0001, out_hi=0xFFFE, C=V=1, done one cycle. A start with op=ADD during busy is ignored.
- Back-to-back: XOR 0xAAAA^0xAAAA then SHL 0x8001 on consecutive cycles -> Z=1 then out=0x0002, C=1, V=1; op=0xE -> done pulses, outputs unchanged.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control unit (master) and the sequential ALU (slave).
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             sign_flag;
    logic             c_flag;
    logic             zero_flag;
    logic             ovf_flag;

    modport master (
        output start, op, in_a, in_b,
        input  busy, done, out, out_hi, sign_flag, c_flag, zero_flag, ovf_flag
    );

    modport slave (
        input  start, op, in_a, in_b,
        output busy, done, out, out_hi, sign_flag, c_flag, zero_flag, ovf_flag
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake: single-cycle arithmetic/logic ops and a
// WIDTH-cycle unsigned shift-add multiplier producing a double-width product.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);

    localparam logic [3:0] OpAdd = 4'h0;
    localparam logic [3:0] OpAdc = 4'h1;
    localparam logic [3:0] OpSub = 4'h2;
    localparam logic [3:0] OpSbb = 4'h3;
    localparam logic [3:0] OpInc = 4'h4;
    localparam logic [3:0] OpDec = 4'h5;
    localparam logic [3:0] OpAnd = 4'h6;
    localparam logic [3:0] OpOr  = 4'h7;
    localparam logic [3:0] OpXor = 4'h8;
    localparam logic [3:0] OpNot = 4'h9;
    localparam logic [3:0] OpShl = 4'hA;
    localparam logic [3:0] OpShr = 4'hB;
    localparam logic [3:0] OpMul = 4'hC;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   out_hi_q, out_hi_d;
    logic               s_q, s_d, c_q, c_d, z_q, z_d, v_q, v_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     arith;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_valid;

    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_cat;
    logic [2*WIDTH-1:0] mul_next;

    // Single-cycle datapath; arithmetic runs WIDTH+1 bits wide so bit WIDTH is carry/borrow.
    always_comb begin
        arith     = '0;
        b_eff     = bus.in_b;
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_valid = 1'b1;
        case (bus.op)
            OpAdd, OpAdc, OpInc: begin
                if (bus.op == OpInc) b_eff = WIDTH'(1);
                arith   = {1'b0, bus.in_a} + {1'b0, b_eff}
                        + {{WIDTH{1'b0}}, (bus.op == OpAdc) & c_q};
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                alu_v   = (bus.in_a[WIDTH-1] == b_eff[WIDTH-1])
                        && (alu_res[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OpSub, OpSbb, OpDec: begin
                if (bus.op == OpDec) b_eff = WIDTH'(1);
                arith   = {1'b0, bus.in_a} - {1'b0, b_eff}
                        - {{WIDTH{1'b0}}, (bus.op == OpSbb) & c_q};
                alu_res = arith[WIDTH-1:0];
                alu_c   = arith[WIDTH];
                alu_v   = (bus.in_a[WIDTH-1] != b_eff[WIDTH-1])
                        && (alu_res[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OpAnd: alu_res = bus.in_a & bus.in_b;
            OpOr:  alu_res = bus.in_a | bus.in_b;
            OpXor: alu_res = bus.in_a ^ bus.in_b;
            OpNot: alu_res = ~bus.in_a;
            OpShl: begin
                alu_res = {bus.in_a[WIDTH-2:0], 1'b0};
                alu_c   = bus.in_a[WIDTH-1];
                alu_v   = bus.in_a[WIDTH-1] ^ bus.in_a[WIDTH-2];
            end
            OpShr: begin
                alu_res = {1'b0, bus.in_a[WIDTH-1:1]};
                alu_c   = bus.in_a[0];
            end
            default: alu_valid = 1'b0;
        endcase
    end

    // One shift-add step: add multiplicand into the upper half, then shift the pair right.
    always_comb begin
        mul_addend = mplier_q[0] ? mcand_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
        mul_cat    = {mul_sum, acc_q[WIDTH-1:0]};
        mul_next   = (2*WIDTH)'(mul_cat >> 1);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        out_d    = out_q;
        out_hi_d = out_hi_q;
        s_d      = s_q;
        c_d      = c_q;
        z_d      = z_q;
        v_d      = v_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.op == OpMul) begin
                        mcand_d  = bus.in_a;
                        mplier_d = bus.in_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        done_d = 1'b1;
                        // Reserved ops acknowledge without touching results or flags.
                        if (alu_valid) begin
                            out_d    = alu_res;
                            out_hi_d = '0;
                            s_d      = alu_res[WIDTH-1];
                            c_d      = alu_c;
                            z_d      = (alu_res == '0);
                            v_d      = alu_v;
                        end
                    end
                end
            end
            StMul: begin
                acc_d    = mul_next;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = StIdle;
                    done_d   = 1'b1;
                    out_d    = mul_next[WIDTH-1:0];
                    out_hi_d = mul_next[2*WIDTH-1:WIDTH];
                    s_d      = mul_next[2*WIDTH-1];
                    z_d      = (mul_next == '0);
                    c_d      = (mul_next[2*WIDTH-1:WIDTH] != '0);
                    v_d      = (mul_next[2*WIDTH-1:WIDTH] != '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            out_hi_q <= '0;
            s_q      <= 1'b0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            s_q      <= s_d;
            c_q      <= c_d;
            z_q      <= z_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy      = (state_q == StMul);
    assign bus.done      = done_q;
    assign bus.out       = out_q;
    assign bus.out_hi    = out_hi_q;
    assign bus.sign_flag = s_q;
    assign bus.c_flag    = c_q;
    assign bus.zero_flag = z_q;
    assign bus.ovf_flag  = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;

    localparam int unsigned W    = 16;
    localparam longint      FULL = longint'(1) << W;
    localparam longint      HALF = longint'(1) << (W - 1);
    localparam longint      MASK = FULL - 1;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    longint m_out, m_hi;
    bit     m_s, m_c, m_z, m_v;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint sx(input longint x);
        return (x >= HALF) ? x - FULL : x;
    endfunction

    function automatic bit oor(input longint sr);
        return (sr > HALF - 1) || (sr < -HALF);
    endfunction

    task automatic set_res(input longint r, input bit c, input bit v);
        m_out = r & MASK;
        m_hi  = 0;
        m_s   = ((m_out >> (W - 1)) & 1) != 0;
        m_z   = (m_out == 0);
        m_c   = c;
        m_v   = v;
    endtask

    task automatic model_reset();
        m_out = 0; m_hi = 0; m_s = 0; m_c = 0; m_z = 0; m_v = 0;
    endtask

    task automatic model_apply(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint ua, ub, cin, r, sr;
        longint unsigned p;
        ua  = longint'(a);
        ub  = (op == 4'h4 || op == 4'h5) ? 1 : longint'(b);
        cin = (op == 4'h1 || op == 4'h3) ? longint'(m_c) : 0;
        case (op)
            4'h0, 4'h1, 4'h4: begin
                r  = ua + ub + cin;
                sr = sx(ua) + sx(ub) + cin;
                set_res(r, r > MASK, oor(sr));
            end
            4'h2, 4'h3, 4'h5: begin
                r  = ua - ub - cin;
                sr = sx(ua) - sx(ub) - cin;
                set_res(r, r < 0, oor(sr));
            end
            4'h6: set_res(ua & ub, 0, 0);
            4'h7: set_res(ua | ub, 0, 0);
            4'h8: set_res(ua ^ ub, 0, 0);
            4'h9: set_res(~ua, 0, 0);
            4'hA: set_res(ua * 2, ((ua >> (W - 1)) & 1) != 0, oor(sx(ua) * 2));
            4'hB: set_res(ua >> 1, (ua & 1) != 0, 0);
            4'hC: begin
                p     = longint'(a) * longint'(b);
                m_out = longint'(p) & MASK;
                m_hi  = longint'(p >> W);
                m_z   = (p == 0);
                m_c   = (m_hi != 0);
                m_v   = m_c;
                m_s   = ((m_hi >> (W - 1)) & 1) != 0;
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out"},    bus.out,       m_out);
        check({tag, ".out_hi"}, bus.out_hi,    m_hi);
        check({tag, ".S"},      bus.sign_flag, m_s);
        check({tag, ".C"},      bus.c_flag,    m_c);
        check({tag, ".Z"},      bus.zero_flag, m_z);
        check({tag, ".V"},      bus.ovf_flag,  m_v);
    endtask

    // Issue one op, wait (bounded) for done, compare latency, busy span and results.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit inject);
        int cycles;
        int busy_cnt;
        int exp_lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.in_a = a; bus.in_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        busy_cnt  = bus.busy ? 1 : 0;
        cycles    = 0;
        while (!bus.done && cycles < 4 * W) begin
            if (inject && cycles == 3) begin
                bus.start = 1'b1; bus.op = 4'h0;
                bus.in_a = W'($urandom); bus.in_b = W'($urandom);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            cycles++;
            if (bus.busy) busy_cnt++;
        end
        model_apply(op, a, b);
        exp_lat = (op == 4'hC) ? W : 0;
        check({tag, ".latency"}, cycles, exp_lat);
        check({tag, ".busy_cycles"}, busy_cnt, exp_lat);
        check({tag, ".done"}, bus.done, 1'b1);
        check_outputs(tag);
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        check({tag, ".done_low"}, bus.done, 1'b0);
        check({tag, ".busy_low"}, bus.busy, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        model_reset();
        check({tag, ".busy"}, bus.busy, 1'b0);
        check({tag, ".done"}, bus.done, 1'b0);
        check_outputs(tag);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(HALF - 1);
            3:       return W'(HALF);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.in_a  = '0;
        bus.in_b  = '0;
        #12;
        check_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle("post_por");

        do_op("add_wrap", 4'h0, 16'hFFFF, 16'h0001, 1'b0);
        check("add_wrap.lit_c", bus.c_flag, 1'b1);
        do_op("adc", 4'h1, 16'h0001, 16'h0001, 1'b0);
        check("adc.lit_out", bus.out, 16'h0003);
        do_op("add_ovf", 4'h0, 16'h7FFF, 16'h0001, 1'b0);
        do_op("sub_borrow", 4'h2, 16'h0003, 16'h0005, 1'b0);
        do_op("sbb", 4'h3, 16'h0010, 16'h0001, 1'b0);
        check("sbb.lit_out", bus.out, 16'h000E);
        do_op("dec_zero", 4'h5, 16'h0000, 16'h1234, 1'b0);
        do_op("inc_ovf", 4'h4, 16'h7FFF, 16'h0000, 1'b0);

        do_op("mul_max", 4'hC, 16'hFFFF, 16'hFFFF, 1'b1);
        check("mul_max.lit_lo", bus.out, 16'h0001);
        check("mul_max.lit_hi", bus.out_hi, 16'hFFFE);
        idle_cycle("after_mul");
        check_outputs("mul_hold");

        do_op("xor_self", 4'h8, 16'hAAAA, 16'hAAAA, 1'b0);
        do_op("shl", 4'hA, 16'h8001, 16'h0000, 1'b0);
        do_op("reserved_e", 4'hE, 16'h1234, 16'h5678, 1'b0);
        do_op("mul_zero", 4'hC, 16'h0000, 16'hBEEF, 1'b0);

        // Reset while idle.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_idle");
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle("after_rst_idle");

        // Reset during the fifth multiply cycle aborts it with no done.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'hC; bus.in_a = 16'h1234; bus.in_b = 16'h00FF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_mul");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) idle_cycle("after_rst_mul");
        do_op("add_after_rst", 4'h0, 16'h1111, 16'h2222, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            do_op($sformatf("rnd%0d_op%0h", i, rop), rop, pick(), pick(), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 4) == 0) idle_cycle("rnd_gap");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
